// File: rtl/servo_pwm_deadtime_pkg.sv
// Shared types and defaults for the servo PWM / dead-time generator.
package servo_pwm_deadtime_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;
  localparam int unsigned DT_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DEAD = 2'd3
  } dt_state_e;

endpackage

// File: rtl/servo_pwm_deadtime_deadtime.sv
// Dead-time inserter: turns the raw compare level into a non-overlapping
// complementary pwm / pwm_n pair with registered outputs.
module servo_deadtime
  import servo_pwm_deadtime_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            raw,
  input  logic [DT_W-1:0] dead_time,
  output logic            pwm,
  output logic            pwm_n
);

  dt_state_e       state;
  logic            target;
  logic [DT_W-1:0] dcnt;
  logic [DT_W-1:0] dt_lat;
  logic            leave;

  // Steady states are left when raw disagrees with the level being driven.
  always_comb begin
    leave = 1'b0;
    case (state)
      ST_IDLE: leave = 1'b1;
      ST_HIGH: leave = ~raw;
      ST_LOW:  leave = raw;
      default: leave = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      target <= 1'b0;
      dcnt   <= '0;
      dt_lat <= '0;
      pwm    <= 1'b0;
      pwm_n  <= 1'b0;
    end else if (!enable) begin
      state <= ST_IDLE;
      dcnt  <= '0;
      pwm   <= 1'b0;
      pwm_n <= 1'b0;
    end else if (state == ST_DEAD) begin
      // dcnt counts the both-low cycles already shown, so exit when it hits dt_lat.
      if (raw != target) begin
        target <= raw;
        dcnt   <= DT_W'(1);
      end else if (dcnt == dt_lat) begin
        state <= target ? ST_HIGH : ST_LOW;
        pwm   <= target;
        pwm_n <= ~target;
        dcnt  <= '0;
      end else begin
        dcnt <= dcnt + DT_W'(1);
      end
    end else if (leave) begin
      target <= raw;
      if (dead_time == '0) begin
        state <= raw ? ST_HIGH : ST_LOW;
        pwm   <= raw;
        pwm_n <= ~raw;
      end else begin
        state  <= ST_DEAD;
        dcnt   <= DT_W'(1);
        dt_lat <= dead_time;
        pwm    <= 1'b0;
        pwm_n  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/servo_pwm_deadtime.sv
// Edge-aligned PWM carrier with double-buffered period/duty feeding the
// dead-time inserter that drives the commutation stage.
module servo_pwm_deadtime
  import servo_pwm_deadtime_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT,
  parameter int unsigned DT_W  = DT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dead_time,
  input  logic             load,
  output logic             pwm,
  output logic             pwm_n,
  output logic             cycle_start,
  output logic [CNT_W-1:0] duty_active
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_sh;
  logic [CNT_W-1:0] duty_sh;
  logic [CNT_W-1:0] period_pend;
  logic [CNT_W-1:0] duty_pend;
  logic             pend_valid;
  logic             enable_q;
  logic             en_rise;
  logic             wrap;
  logic             raw;
  logic [CNT_W-1:0] period_eff;
  logic [CNT_W-1:0] duty_eff;

  // On the enable rising edge the live inputs are already in effect for the
  // first counter cycle, so compare and wrap use them instead of the stale shadow.
  always_comb begin
    en_rise    = enable & ~enable_q;
    period_eff = en_rise ? period : period_sh;
    duty_eff   = en_rise ? duty : duty_sh;
    wrap       = enable & (cnt == period_eff);
    raw        = (cnt < duty_eff);
  end

  assign duty_active = duty_sh;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      period_sh   <= '0;
      duty_sh     <= '0;
      period_pend <= '0;
      duty_pend   <= '0;
      pend_valid  <= 1'b0;
      enable_q    <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      enable_q    <= enable;
      cycle_start <= enable & (cnt == '0);

      if (!enable || wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      if (load) begin
        period_pend <= period;
        duty_pend   <= duty;
      end

      if (en_rise) begin
        period_sh <= period;
        duty_sh   <= duty;
      end else if (wrap && pend_valid) begin
        period_sh <= period_pend;
        duty_sh   <= duty_pend;
      end

      if (load) begin
        pend_valid <= 1'b1;
      end else if (en_rise || wrap) begin
        pend_valid <= 1'b0;
      end
    end
  end

  servo_deadtime #(
    .DT_W(DT_W)
  ) u_deadtime (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .raw       (raw),
    .dead_time (dead_time),
    .pwm       (pwm),
    .pwm_n     (pwm_n)
  );

endmodule

// File: tb/tb_servo_pwm_deadtime.sv
// Directed bench for servo_pwm_deadtime: steady-state duty table plus
// hand-written sequences for latency, buffering, enable drop and reset.
module tb_servo_pwm_deadtime;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DT_W  = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  dead_time;
  logic             load;
  logic             pwm;
  logic             pwm_n;
  logic             cycle_start;
  logic [CNT_W-1:0] duty_active;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap_total = 0;

  typedef struct {
    int period;
    int duty;
    int dt;
    int cycles;
    int exp_pwm;
    int exp_pwm_n;
    int exp_cs;
  } vec_t;

  vec_t vecs [9];

  always #5 clk = ~clk;

  servo_pwm_deadtime #(
    .CNT_W(CNT_W),
    .DT_W (DT_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .duty        (duty),
    .dead_time   (dead_time),
    .load        (load),
    .pwm         (pwm),
    .pwm_n       (pwm_n),
    .cycle_start (cycle_start),
    .duty_active (duty_active)
  );

  always @(negedge clk) begin
    if (pwm && pwm_n) overlap_total++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    period    = '0;
    duty      = '0;
    dead_time = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_load(input int p, input int d);
    period = CNT_W'(p);
    duty   = CNT_W'(d);
    load   = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_cs(input string name, output int found);
    found = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (cycle_start) begin
        found = 1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  initial begin
    int np, nn, nc, no, found, first_p, first_n;
    logic [11:0] ep, en, ec;

    // period, duty, dead_time, window, pwm-high, pwm_n-high, cycle_start count
    vecs[0] = '{9,   4,   0, 30, 12,  18, 3};
    vecs[1] = '{99,  50,  3, 100, 47, 47, 1};
    vecs[2] = '{99,  0,   3, 100, 0,  100, 1};
    vecs[3] = '{99,  200, 3, 100, 100, 0, 1};
    vecs[4] = '{19,  5,   2, 40, 6,   26, 2};
    vecs[5] = '{7,   7,   0, 24, 21,  3,  3};
    vecs[6] = '{4,   5,   1, 25, 25,  0,  5};
    vecs[7] = '{9,   1,   2, 30, 0,   21, 3};
    vecs[8] = '{19,  2,   5, 40, 0,   26, 2};

    reset_n   = 1'b0;
    enable    = 1'b0;
    load      = 1'b0;
    period    = '0;
    duty      = '0;
    dead_time = '0;
    @(negedge clk);
    check("reset_state", int'({pwm, pwm_n, cycle_start}) + int'(duty_active), 0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      period    = CNT_W'(vecs[i].period);
      duty      = CNT_W'(vecs[i].duty);
      dead_time = DT_W'(vecs[i].dt);
      enable    = 1'b1;
      repeat (2 * (vecs[i].period + 1) + vecs[i].dt + 4) @(negedge clk);
      np = 0; nn = 0; nc = 0; no = 0;
      repeat (vecs[i].cycles) begin
        @(negedge clk);
        np += int'(pwm);
        nn += int'(pwm_n);
        nc += int'(cycle_start);
        no += int'(pwm & pwm_n);
      end
      check($sformatf("vec%0d_pwm_high", i), np, vecs[i].exp_pwm);
      check($sformatf("vec%0d_pwm_n_high", i), nn, vecs[i].exp_pwm_n);
      check($sformatf("vec%0d_cycle_start", i), nc, vecs[i].exp_cs);
      check($sformatf("vec%0d_overlap", i), no, 0);
    end

    // Exact first-period waveform, period=9 duty=4 dead_time=0.
    do_reset();
    period = 16'd9; duty = 16'd4; dead_time = '0; enable = 1'b1;
    ep = 12'b1100_0000_1111;
    en = 12'b0011_1111_0000;
    ec = 12'b0100_0000_0001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check($sformatf("wave_c%0d", k + 1), int'({pwm, pwm_n, cycle_start}),
            int'({ep[k], en[k], ec[k]}));
      if (k == 0) check("enable_loads_shadow", int'(duty_active), 4);
    end

    // Asynchronous reset while pwm is high.
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (pwm) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("pwm_high_before_reset", found, 1);
    #2 reset_n = 1'b0;
    #1 check("async_reset_outputs", int'({pwm, pwm_n, cycle_start}) + int'(duty_active), 0);
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Dead-time latency, period=99 duty=50 dead_time=3.
    do_reset();
    period = 16'd99; duty = 16'd50; dead_time = 8'd3; enable = 1'b1;
    first_p = -1; first_n = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (pwm && first_p < 0) first_p = k;
      if (pwm_n && first_n < 0) first_n = k;
    end
    check("dt3_first_pwm", first_p, 4);
    check("dt3_first_pwm_n", first_n, 54);

    // Double buffering of duty.
    do_reset();
    period = 16'd99; duty = 16'd20; dead_time = '0; enable = 1'b1;
    repeat (30) @(negedge clk);
    pulse_load(99, 70);
    check("dbuf_hold_old", int'(duty_active), 20);
    wait_cs("dbuf_wrap1_seen", found);
    check("dbuf_apply_new", int'(duty_active), 70);
    np = int'(pwm);
    repeat (99) begin
      @(negedge clk);
      np += int'(pwm);
    end
    check("dbuf_pwm_70", np, 70);
    repeat (20) @(negedge clk);
    pulse_load(99, 30);
    repeat (5) @(negedge clk);
    pulse_load(99, 40);
    check("dbuf_two_loads_hold", int'(duty_active), 70);
    wait_cs("dbuf_wrap2_seen", found);
    check("dbuf_second_load_wins", int'(duty_active), 40);
    np = int'(pwm);
    repeat (99) begin
      @(negedge clk);
      np += int'(pwm);
    end
    check("dbuf_pwm_40", np, 40);

    // Drop enable mid-DEAD, re-enable, and change dead_time while DEAD.
    do_reset();
    period = 16'd19; duty = 16'd10; dead_time = 8'd5; enable = 1'b1;
    repeat (2) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_mid_dead_outputs", int'({pwm, pwm_n, cycle_start}), 0);
    enable = 1'b1;
    first_p = -1; first_n = -1; np = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) check("reenable_cycle_start", int'(cycle_start), 1);
      if (k == 2) dead_time = 8'd2;
      if (pwm && first_p < 0) first_p = k;
      if (pwm_n && first_n < 0) first_n = k;
      np += int'(pwm);
    end
    check("reenable_first_pwm", first_p, 6);
    check("reenable_pwm_width", np, 5);
    check("dt_sampled_first_pwm_n", first_n, 13);
    check("pwm_n_high_before_drop", int'(pwm_n), 1);
    enable = 1'b0;
    @(negedge clk);
    check("drop_while_pwm_n_high", int'({pwm, pwm_n, cycle_start}), 0);

    check("no_overlap_anywhere", overlap_total, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
